// File: rtl/serial_subtractor16.sv
// Bit-serial subtractor: computes A - B - BIN one bit per clock, LSB first,
// and presents difference, borrow, signed overflow and zero flags on completion.
module serial_subtractor16 #(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Rezultati,
   output logic             BOUT,
   output logic             Overflow,
   output logic             Zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             bit_nx;
   logic             br_nx;
   logic [WIDTH-1:0] diff_nx;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      res_d   = res_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      // One full-subtractor slice on the current LSBs.
      bit_nx  = a_q[0] ^ b_q[0] ^ br_q;
      br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      diff_nx = {bit_nx, diff_q[WIDTH-1:1]};

      case (state_q)
         IDLE, DONE: begin
            if (Start) begin
               a_d     = A;
               b_d     = B;
               br_d    = BIN;
               a_msb_d = A[WIDTH-1];
               b_msb_d = B[WIDTH-1];
               diff_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            br_d   = br_nx;
            diff_d = diff_nx;
            cnt_d  = cnt_q + CNT_W'(1);
            // Operand MSBs are shifted out by now, so overflow uses the captured copies.
            if (cnt_q == LAST) begin
               state_d = DONE;
               res_d   = diff_nx;
               bout_d  = br_nx;
               ovf_d   = (a_msb_q ^ b_msb_q) & (diff_nx[WIDTH-1] ^ a_msb_q);
               zero_d  = (diff_nx == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         diff_q  <= '0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         res_q   <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         res_q   <= res_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   assign Busy      = (state_q == RUN);
   assign Done      = (state_q == DONE);
   assign Rezultati = res_q;
   assign BOUT      = bout_q;
   assign Overflow  = ovf_q;
   assign Zero      = zero_q;

endmodule
